res_writeback: RTL and testbench

- Stage directly upstream of the result buffer (res_buffer2) in the NPU datapath.
- Accepts a stream of wide signed accumulator results from the PE/MAC array over a valid/ready handshake.
- Requantizes each result to BIT_DEPTH with a programmable rounding shift and signed saturation.
- Issues one write per sample (wr_en, wr_addr, data) into the result buffer at sequential, wrapping addresses for a programmed job length, then pulses done.

---
 rtl/res_writeback_if.sv | 24 ++
 rtl/res_writeback.sv | 135 +++++++++++++
 tb/tb_res_writeback.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/res_writeback_if.sv
// res_writeback_if: accumulator stream into the writeback stage and its
// write port toward the result buffer.
interface res_writeback_if #(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int ACC_WIDTH  = 32
);
    logic signed [ACC_WIDTH-1:0] acc_in;
    logic                        acc_valid;
    logic                        acc_ready;
    logic                        wr_en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [BIT_DEPTH-1:0]        wr_data;

    modport master (
        output acc_in, acc_valid,
        input  acc_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  acc_in, acc_valid,
        output acc_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/res_writeback.sv
// res_writeback: requantizes accumulator results (rounding shift + signed saturation)
// and writes them to the result buffer. Define RES_WRITEBACK_RELU_EN to add ReLU.
module res_writeback #(
    parameter int BIT_DEPTH   = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [ADDR_WIDTH:0]    length,
    input  logic [SHIFT_WIDTH-1:0] shift,
    res_writeback_if.slave         bus,
    output logic                   busy,
    output logic                   done,
    output logic                   sat_flag
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ACC_WIDTH:0]  ONE     = {{ACC_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        $signed({{(ACC_WIDTH+2-BIT_DEPTH){1'b0}}, {(BIT_DEPTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        $signed({{(ACC_WIDTH+2-BIT_DEPTH){1'b1}}, {(BIT_DEPTH-1){1'b0}}});

    state_t                  state, next_state;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH:0]     len_q;
    logic [SHIFT_WIDTH-1:0]  shift_q;
    logic [ADDR_WIDTH:0]     idx;
    logic                    accept;

    logic signed [ACC_WIDTH:0] acc_ext;
    logic signed [ACC_WIDTH:0] rnd;
    logic signed [ACC_WIDTH:0] rounded;
    logic signed [ACC_WIDTH:0] rect;
    logic [BIT_DEPTH-1:0]      q_data;
    logic                      clamp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        bus.acc_ready = 1'b0;
        busy          = (state != IDLE);
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                bus.acc_ready = 1'b1;
                if (bus.acc_valid && (idx == len_q - 1'b1)) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: next_state = DONE;
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept = bus.acc_valid && bus.acc_ready;

    // Widened by one bit so adding the rounding constant can never overflow.
    always_comb begin
        acc_ext = {bus.acc_in[ACC_WIDTH-1], bus.acc_in};
        rnd     = '0;
        if (shift_q != '0) begin
            rnd = $signed(ONE << (shift_q - 1'b1));
        end
        rounded = (acc_ext + rnd) >>> shift_q;
`ifdef RES_WRITEBACK_RELU_EN
        rect = rounded[ACC_WIDTH] ? '0 : rounded;
`else
        rect = rounded;
`endif
        clamp  = 1'b0;
        q_data = rect[BIT_DEPTH-1:0];
        if (rect > SAT_MAX) begin
            clamp  = 1'b1;
            q_data = SAT_MAX[BIT_DEPTH-1:0];
        end else if (rect < SAT_MIN) begin
            clamp  = 1'b1;
            q_data = SAT_MIN[BIT_DEPTH-1:0];
        end
    end

    // Job parameters latch only from IDLE, so a start seen while busy has no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            len_q       <= '0;
            shift_q     <= '0;
            idx         <= '0;
            sat_flag    <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            if (state == IDLE && start) begin
                base_q   <= base_addr;
                shift_q  <= shift;
                len_q    <= (length > MAX_LEN) ? MAX_LEN : length;
                idx      <= '0;
                sat_flag <= 1'b0;
            end else if (accept) begin
                idx         <= idx + 1'b1;
                bus.wr_en   <= 1'b1;
                bus.wr_addr <= base_q + idx[ADDR_WIDTH-1:0];
                bus.wr_data <= q_data;
                if (clamp) begin
                    sat_flag <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_res_writeback.sv
// tb_res_writeback: directed tests for res_writeback with hand-computed expected writes.
`timescale 1ns/1ps
module tb_res_writeback;
    localparam int BD   = 8;
    localparam int AW   = 10;
    localparam int ACCW = 32;
    localparam int SW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic [SW-1:0] shift = '0;
    logic          busy, done, sat_flag;

    int tests_run = 0;
    int tests_failed = 0;

    res_writeback_if #(.BIT_DEPTH(BD), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW)) bus();

    res_writeback #(.BIT_DEPTH(BD), .ADDR_WIDTH(AW), .ACC_WIDTH(ACCW), .SHIFT_WIDTH(SW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .shift(shift), .bus(bus), .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Write log captured mid-cycle, tagged with the cycle number.
    int wa[$];
    int wd[$];
    int wc[$];
    int done_cnt = 0;
    int done_cyc = -1;
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wa.push_back(int'(bus.wr_addr));
            wd.push_back(int'($signed(bus.wr_data)));
            wc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete();
        done_cnt = 0; done_cyc = -1;
    endtask

    task automatic start_job(input int b, input int len, input int sh, output int scyc);
        base_addr = AW'(b); length = (AW+1)'(len); shift = SW'(sh); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scyc = cyc;
    endtask

    task automatic feed(input int samples[$], input bit stall, input int glitch);
        bit took;
        for (int i = 0; i < samples.size(); i++) begin
            took = 1'b0;
            bus.acc_valid = 1'b1;
            bus.acc_in = ACCW'(samples[i]);
            if (i == glitch) begin
                start = 1'b1; base_addr = AW'(500); length = (AW+1)'(7);
            end
            for (int t = 0; t < 50 && !took; t++) begin
                took = (bus.acc_ready === 1'b1);
                @(posedge clk); #1;
            end
            start = 1'b0;
            bus.acc_valid = 1'b0;
            if (!took) begin
                tests_run++; tests_failed++;
                $display("[TB] FAIL feed_timeout sample %0d: acc_ready got 0, expected 1", i);
                return;
            end
            if (stall) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int t = 0; t < limit && !seen; t++) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++; if (bus.acc_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_acc_ready got %b expected 0", bus.acc_ready); end
        tests_run++; if (bus.wr_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wr_en got %b expected 0", bus.wr_en); end
        tests_run++; if (bus.wr_addr !== '0) begin tests_failed++; $display("[TB] FAIL reset_wr_addr got %0d expected 0", bus.wr_addr); end
        tests_run++; if (bus.wr_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_wr_data got %0d expected 0", bus.wr_data); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b expected 0", done); end
        tests_run++; if (sat_flag !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sat_flag got %b expected 0", sat_flag); end
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int s; bit seen; int q[$]; int exp_d[$];
        clear_log();
        q = {300, 301, 302, 303};
        exp_d = {75, 75, 76, 76};
        start_job(5, 4, 2, s);
        feed(q, 1'b0, -1);
        wait_done(20, seen);
        @(posedge clk); #1;
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL basic_done_timeout got none expected done pulse"); end
        tests_run++; if (wa.size() != 4) begin tests_failed++; $display("[TB] FAIL basic_write_count got %0d expected 4", wa.size()); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (((i < wa.size()) ? wa[i] : -1) != 5 + i) begin tests_failed++; $display("[TB] FAIL basic_addr[%0d] got %0d expected %0d", i, (i < wa.size()) ? wa[i] : -1, 5 + i); end
            tests_run++; if (((i < wd.size()) ? wd[i] : -999) != exp_d[i]) begin tests_failed++; $display("[TB] FAIL basic_data[%0d] got %0d expected %0d", i, (i < wd.size()) ? wd[i] : -999, exp_d[i]); end
            tests_run++; if (((i < wc.size()) ? wc[i] : -1) != s + 1 + i) begin tests_failed++; $display("[TB] FAIL basic_wr_cycle[%0d] got %0d expected %0d", i, (i < wc.size()) ? wc[i] : -1, s + 1 + i); end
        end
        tests_run++; if (done_cyc != s + 5) begin tests_failed++; $display("[TB] FAIL basic_done_cycle got %0d expected %0d", done_cyc, s + 5); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL basic_done_count got %0d expected 1", done_cnt); end
        tests_run++; if (sat_flag !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_sat_flag got %b expected 0", sat_flag); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_busy_after got %b expected 0", busy); end
    endtask

    task automatic test_wrap_stall();
        int s; bit seen; int q[$]; int exp_a[$];
        clear_log();
        q = {1, 2, 3, 4};
        exp_a = {1022, 1023, 0, 1};
        start_job(1022, 4, 0, s);
        feed(q, 1'b1, -1);
        wait_done(20, seen);
        @(posedge clk); #1;
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL wrap_done_timeout got none expected done pulse"); end
        tests_run++; if (wa.size() != 4) begin tests_failed++; $display("[TB] FAIL wrap_write_count got %0d expected 4", wa.size()); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (((i < wa.size()) ? wa[i] : -1) != exp_a[i]) begin tests_failed++; $display("[TB] FAIL wrap_addr[%0d] got %0d expected %0d", i, (i < wa.size()) ? wa[i] : -1, exp_a[i]); end
            tests_run++; if (((i < wd.size()) ? wd[i] : -999) != i + 1) begin tests_failed++; $display("[TB] FAIL wrap_data[%0d] got %0d expected %0d", i, (i < wd.size()) ? wd[i] : -999, i + 1); end
            tests_run++; if (((i < wc.size()) ? wc[i] : -1) != s + 1 + 2 * i) begin tests_failed++; $display("[TB] FAIL wrap_wr_cycle[%0d] got %0d expected %0d", i, (i < wc.size()) ? wc[i] : -1, s + 1 + 2 * i); end
        end
    endtask

    task automatic test_saturation();
        int s; bit seen; int q[$]; int exp_d[$]; int exp_m5;
`ifdef RES_WRITEBACK_RELU_EN
        exp_d = {127, 0};
        exp_m5 = 0;
`else
        exp_d = {127, -128};
        exp_m5 = -2;
`endif
        clear_log();
        q = {1000, -1000};
        start_job(40, 2, 0, s);
        feed(q, 1'b0, -1);
        wait_done(20, seen);
        @(posedge clk); #1;
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL sat_done_timeout got none expected done pulse"); end
        for (int i = 0; i < 2; i++) begin
            tests_run++; if (((i < wd.size()) ? wd[i] : -999) != exp_d[i]) begin tests_failed++; $display("[TB] FAIL sat_data[%0d] got %0d expected %0d", i, (i < wd.size()) ? wd[i] : -999, exp_d[i]); end
        end
        tests_run++; if (sat_flag !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_flag_set got %b expected 1", sat_flag); end

        clear_log();
        q = {-5};
        start_job(50, 1, 1, s);
        feed(q, 1'b0, -1);
        wait_done(20, seen);
        @(posedge clk); #1;
        tests_run++; if (((wd.size() > 0) ? wd[0] : -999) != exp_m5) begin tests_failed++; $display("[TB] FAIL round_neg5 got %0d expected %0d", (wd.size() > 0) ? wd[0] : -999, exp_m5); end
        tests_run++; if (sat_flag !== 1'b0) begin tests_failed++; $display("[TB] FAIL round_sat_flag got %b expected 0", sat_flag); end
    endtask

    task automatic test_zero_length();
        int s; bit seen; int q[$];
        q = {1000};
        start_job(60, 1, 0, s);
        feed(q, 1'b0, -1);
        wait_done(20, seen);
        @(posedge clk); #1;
        tests_run++; if (sat_flag !== 1'b1) begin tests_failed++; $display("[TB] FAIL zero_pre_sat got %b expected 1", sat_flag); end
        clear_log();
        start_job(3, 0, 0, s);
        wait_done(10, seen);
        @(posedge clk); #1;
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL zero_done_timeout got none expected done pulse"); end
        tests_run++; if (done_cyc != s) begin tests_failed++; $display("[TB] FAIL zero_done_cycle got %0d expected %0d", done_cyc, s); end
        tests_run++; if (wa.size() != 0) begin tests_failed++; $display("[TB] FAIL zero_write_count got %0d expected 0", wa.size()); end
        tests_run++; if (sat_flag !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_sat_cleared got %b expected 0", sat_flag); end
    endtask

    task automatic test_start_while_busy();
        int s; bit seen; int q[$];
        clear_log();
        q = {1, 2, 3, 4};
        start_job(10, 4, 0, s);
        feed(q, 1'b0, 1);
        wait_done(20, seen);
        @(posedge clk); #1;
        tests_run++; if (wa.size() != 4) begin tests_failed++; $display("[TB] FAIL busy_write_count got %0d expected 4", wa.size()); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (((i < wa.size()) ? wa[i] : -1) != 10 + i) begin tests_failed++; $display("[TB] FAIL busy_addr[%0d] got %0d expected %0d", i, (i < wa.size()) ? wa[i] : -1, 10 + i); end
        end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL busy_done_count got %0d expected 1", done_cnt); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_after_job got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid_job();
        int s; bit seen; int q[$];
        clear_log();
        q = {1000, 1000};
        start_job(100, 8, 0, s);
        feed(q, 1'b0, -1);
        tests_run++; if (bus.wr_en !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_pre_wr_en got %b expected 1", bus.wr_en); end
        tests_run++; if (sat_flag !== 1'b1) begin tests_failed++; $display("[TB] FAIL midrst_pre_sat got %b expected 1", sat_flag); end
        bus.acc_valid = 1'b1; bus.acc_in = 7;
        #2 rst = 1'b1;
        #1;
        tests_run++; if (bus.wr_en !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_wr_en got %b expected 0", bus.wr_en); end
        tests_run++; if (bus.acc_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_acc_ready got %b expected 0", bus.acc_ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_busy got %b expected 0", busy); end
        tests_run++; if (sat_flag !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_sat got %b expected 0", sat_flag); end
        clear_log();
        bus.acc_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (wa.size() != 0) begin tests_failed++; $display("[TB] FAIL midrst_writes got %0d expected 0", wa.size()); end
        tests_run++; if (done_cnt != 0) begin tests_failed++; $display("[TB] FAIL midrst_done got %0d expected 0", done_cnt); end
        q = {5, 6};
        start_job(0, 2, 0, s);
        feed(q, 1'b0, -1);
        wait_done(20, seen);
        @(posedge clk); #1;
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL post_done_timeout got none expected done pulse"); end
        for (int i = 0; i < 2; i++) begin
            tests_run++; if (((i < wa.size()) ? wa[i] : -1) != i) begin tests_failed++; $display("[TB] FAIL post_addr[%0d] got %0d expected %0d", i, (i < wa.size()) ? wa[i] : -1, i); end
            tests_run++; if (((i < wd.size()) ? wd[i] : -999) != 5 + i) begin tests_failed++; $display("[TB] FAIL post_data[%0d] got %0d expected %0d", i, (i < wd.size()) ? wd[i] : -999, 5 + i); end
        end
    endtask

    task automatic test_full_length(input int b, input int len);
        int s; bit seen; int q[$]; int hits[1024]; int bad;
        clear_log();
        for (int i = 0; i < 1024; i++) begin
            q.push_back(0);
            hits[i] = 0;
        end
        start_job(b, len, 0, s);
        feed(q, 1'b0, -1);
        wait_done(20, seen);
        @(posedge clk); #1;
        foreach (wa[i]) hits[wa[i]]++;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (hits[i] != 1) bad++;
        tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL full%0d_done_timeout got none expected done pulse", len); end
        tests_run++; if (wa.size() != 1024) begin tests_failed++; $display("[TB] FAIL full%0d_write_count got %0d expected 1024", len, wa.size()); end
        tests_run++; if (bad != 0) begin tests_failed++; $display("[TB] FAIL full%0d_coverage got %0d bad addresses expected 0", len, bad); end
        tests_run++; if (((wa.size() > 0) ? wa[0] : -1) != b) begin tests_failed++; $display("[TB] FAIL full%0d_first_addr got %0d expected %0d", len, (wa.size() > 0) ? wa[0] : -1, b); end
        tests_run++; if (((wa.size() > 0) ? wa[wa.size()-1] : -1) != ((b + 1023) % 1024)) begin tests_failed++; $display("[TB] FAIL full%0d_last_addr got %0d expected %0d", len, (wa.size() > 0) ? wa[wa.size()-1] : -1, (b + 1023) % 1024); end
        tests_run++; if (done_cnt != 1) begin tests_failed++; $display("[TB] FAIL full%0d_done_count got %0d expected 1", len, done_cnt); end
    endtask

    initial begin
        bus.acc_valid = 1'b0;
        bus.acc_in = '0;
        test_reset();
        test_basic();
        test_wrap_stall();
        test_saturation();
        test_zero_length();
        test_start_while_busy();
        test_reset_mid_job();
        test_full_length(300, 1024);
        test_full_length(7, 1500);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
